// File: rtl/axi_read_responder.sv
// ---------------------------------------------------------------------------
// axi_read_responder
//
// AXI4 read-channel responder for instruction-cache refills and uncached
// fetches. An accepted AR request starts an INCR burst of 32-bit beats read
// from an internal word memory. The first beat is preceded by LATENCY extra
// wait cycles, and R-channel backpressure is honoured. A side write port
// preloads the program image and is accepted in any state.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   s_araddr   burst start byte address (bits [1:0] ignored)
//   s_arlen    burst length minus one
//   s_arvalid  read address valid
//   s_arready  read address ready (registered)
//   s_rdata    read data
//   s_rresp    2'b00 OKAY, 2'b10 SLVERR for an out-of-range beat
//   s_rlast    final beat of the burst
//   s_rvalid   read data valid
//   s_rready   read data ready
//   mem_we     preload write enable
//   mem_waddr  preload word index
//   mem_wdata  preload data
// ---------------------------------------------------------------------------
module axi_read_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
    parameter int          LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  s_araddr,
    input  logic [3:0]                   s_arlen,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [31:0]                  s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rlast,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    input  logic [31:0]                  mem_wdata
);

    localparam int          AW   = $clog2(MEM_WORDS);
    // Byte span of the memory, kept 33 bits wide so it cannot overflow.
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t      state, state_n;
    logic [31:0] addr, addr_n;
    logic [3:0]  beats_left, beats_n;
    logic [3:0]  wait_cnt, wait_n;
    logic        arready_n, rvalid_n, rlast_n;
    logic        load_beat;
    logic [31:0] beat_addr;
    logic [31:0] beat_off;
    logic        beat_ok;
    logic [AW-1:0] beat_idx;

    logic [31:0] mem [MEM_WORDS];

    // Unsigned offset check: addresses below BASE_ADDR wrap to huge offsets
    // and therefore fail the same comparison as addresses above the top.
    function automatic logic range_ok(input logic [31:0] off);
        return {1'b0, off} < SPAN;
    endfunction

    assign beat_off = beat_addr - BASE_ADDR;
    assign beat_ok  = range_ok(beat_off);
    assign beat_idx = beat_off[AW+1:2];

    // Preload port; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            beats_left <= '0;
            wait_cnt   <= '0;
            s_arready  <= 1'b0;
            s_rvalid   <= 1'b0;
            s_rlast    <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            beats_left <= beats_n;
            wait_cnt   <= wait_n;
            s_arready  <= arready_n;
            s_rvalid   <= rvalid_n;
            s_rlast    <= rlast_n;
        end
    end

    // Beat data register. The memory read uses the pre-edge contents, so a
    // preload to the same word in the same cycle is seen only by later reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_rdata <= '0;
            s_rresp <= 2'b00;
        end else if (load_beat) begin
            s_rdata <= beat_ok ? mem[beat_idx] : 32'h0;
            s_rresp <= beat_ok ? 2'b00 : 2'b10;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        beats_n   = beats_left;
        wait_n    = wait_cnt;
        rvalid_n  = s_rvalid;
        rlast_n   = s_rlast;
        load_beat = 1'b0;
        beat_addr = addr;

        case (state)
            S_IDLE: begin
                if (s_arvalid && s_arready) begin
                    state_n = S_WAIT;
                    addr_n  = s_araddr & 32'hFFFF_FFFC;
                    beats_n = s_arlen;
                    wait_n  = 4'(LATENCY);
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_n   = S_BURST;
                    load_beat = 1'b1;
                    beat_addr = addr;
                    rvalid_n  = 1'b1;
                    rlast_n   = (beats_left == 4'd0);
                end else begin
                    wait_n = wait_cnt - 4'd1;
                end
            end
            S_BURST: begin
                if (s_rvalid && s_rready) begin
                    if (s_rlast) begin
                        state_n  = S_IDLE;
                        rvalid_n = 1'b0;
                        rlast_n  = 1'b0;
                    end else begin
                        // Load the next beat on the handshake edge so the
                        // burst streams without bubbles.
                        addr_n    = addr + 32'd4;
                        beats_n   = beats_left - 4'd1;
                        load_beat = 1'b1;
                        beat_addr = addr + 32'd4;
                        rlast_n   = (beats_left == 4'd1);
                    end
                end
            end
            default: begin
                state_n  = S_IDLE;
                rvalid_n = 1'b0;
                rlast_n  = 1'b0;
            end
        endcase

        // Registered ready: high in every cycle spent idle after reset.
        arready_n = (state_n == S_IDLE);
    end

endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

AXI4 read-channel responder (slave) serving the read bursts that the instruction cache issues. It answers an AR handshake with an INCR burst of 32-bit beats read from an internal word memory. It adds a programmable initial latency and honours R-channel backpressure. It sits in the SoC test fabric as the memory-side endpoint for the cache's line refills (8 beats) and uncached fetches (1 beat). A side write port preloads the program image.

## Interface
Parameters:
- MEM_WORDS, 1024: memory depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'hBFC0_0000: byte address of word 0; must be aligned to MEM_WORDS*4.
- LATENCY, 2: extra wait cycles between the AR handshake and the first R beat; valid range 0–15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- s_araddr  in  32  burst start byte address; bits [1:0] are ignored.
- s_arlen  in  4  burst length minus 1 (0 = 1 beat, 7 = 8 beats).
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  32  read data.
- s_rresp  out  2  2'b00 OKAY; 2'b10 SLVERR for an out-of-range beat.
- s_rlast  out  1  final beat of the burst.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- mem_we  in  1  preload write enable.
- mem_waddr  in  log2(MEM_WORDS)  preload word index.
- mem_wdata  in  32  preload data.

## Operation
- States:
  - IDLE: s_arready=1.
  - WAIT: latency countdown.
  - BURST: s_rvalid=1.
- IDLE → WAIT on s_arvalid&&s_arready.
  - Capture the word address {araddr[31:2],2'b00}, beats_left=arlen, and wait_cnt=LATENCY.
  - s_arready drops in the next cycle.
- WAIT → BURST when wait_cnt==0.
  - The decrement happens in WAIT, so WAIT lasts LATENCY+1 cycles; with LATENCY=0 it lasts 1 cycle.
  - On leaving WAIT, register the first beat into s_rdata and s_rresp, and set s_rlast=(beats_left==0).
- BURST, on s_rvalid&&s_rready:
  - If s_rlast: go to IDLE and clear s_rvalid and s_rlast.
  - Otherwise: address +4, beats_left−1, and register the next beat. s_rvalid stays 1, so there is no bubble between beats.
- BURST without s_rready: s_rdata, s_rresp and s_rlast hold stable.
- Range check, applied per beat: in range iff (addr−BASE_ADDR) < MEM_WORDS*4, as an unsigned 32-bit comparison.
  - In range: data is mem[(addr−BASE_ADDR)>>2] and s_rresp=00.
  - Out of range: data is 0 and s_rresp=10.
  - The address accumulator is 32-bit and wraps modulo 2^32. There is no wrap within the memory; beats past the top are SLVERR.
- Preload:
  - Accepted in every state.
  - A write and a beat load to the same word in the same cycle return the old data (read-before-write).
- Only one outstanding burst. Further AR requests wait in IDLE. No write channel.

## Timing
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - s_arready=0, s_rvalid=0, s_rlast=0, s_rdata=0, s_rresp=0.
  - Memory contents are untouched.
  - s_arready rises in the first cycle after rst returns high.
- Reset mid-burst aborts the burst with no further beats. A partially consumed burst is not resumed.
- Latency: if AR handshakes at edge T, the first beat is valid from T+LATENCY+1 through the next edge. With continuous s_rready, an N-beat burst completes at edge T+LATENCY+N+1.
- After the last beat handshakes, s_arready=1 in the following cycle. Minimum AR-to-AR spacing is LATENCY+N+2 cycles.
- s_rvalid, once asserted, is never deasserted before the handshake.

## Test plan
- Refill burst:
  - Preload words 0–7 with 0x1000_0000+i.
  - Issue araddr=0xBFC0_0000, arlen=7, LATENCY=2, with s_rready held 1.
  - Expect: first beat 3 cycles after the handshake; 8 consecutive beats 0x1000_0000..0x1000_0007; s_rlast only on beat 8; s_rresp=00.
- Single uncached fetch:
  - Issue araddr=0xBFC0_0014, arlen=0.
  - Expect: one beat carrying mem[5], with s_rlast=1 on that beat; s_arready=1 the cycle after.
- Backpressure:
  - 8-beat burst with s_rready toggled 1,0,0,1,...
  - Expect: s_rdata, s_rresp and s_rlast stable across every stalled cycle; all 8 words delivered in order with none lost or duplicated.
- Boundary SLVERR:
  - Issue araddr=BASE+(MEM_WORDS−2)*4, arlen=3.
  - Expect: beats 1–2 return data with 00; beats 3–4 return 0x0 with 10; s_rlast on beat 4.
- Reset mid-burst:
  - Assert rst=0 after 3 beats of an 8-beat burst.
  - Expect: s_rvalid=0 and s_arready=0 at the next edge; s_arready=1 one cycle after release; a new burst returns correct data.
- Preload collision:
  - Hold mem_we to word 2 with 0xDEAD_BEEF in the cycle that beat 2 loads, where old data is 0x1000_0002.
  - Expect: beat 2 = 0x1000_0002; a follow-up read of word 2 returns 0xDEAD_BEEF.
